spi_wide_host: RTL and testbench

- Byte-parallel SPI initiator: the host end of the 8-bit-wide SPI link whose target samples an 8-bit MOSI word and drives an 8-bit MISO word on every SCLK rising edge.
- Takes a transaction request (write length, read length), streams write bytes from a valid/ready source and returns read bytes as strobed words.
- Generates SCLK, CS_N and MOSI, and samples MISO; used by on-chip test logic and FPGA-side bring-up benches.

---
 rtl/spi_wide_host.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_wide_host.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wide_host.sv
// Byte-parallel SPI host: streams wr_len bytes out, then reads rd_len bytes back over an 8-bit MOSI/MISO link.
// The slot engine shares one divider between the SETUP, slot, HOLD and GAP timing.
`timescale 1ns/1ps

module spi_wide_host #(
    parameter int CLK_DIV    = 2,
    parameter int TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] wr_len,
    input  logic [7:0] rd_len,
    output logic       busy,
    output logic       done,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sclk,
    output logic       cs_n,
    output logic [7:0] mosi,
    input  logic [7:0] miso
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND);
    localparam bit HAS_TURN = (TURNAROUND > 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_TURN,
        ST_READ,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Handshake: tx_data is captured on the edge that raises tx_ready; the source
    // keeps tx_data stable while tx_valid=1 and advances after the tx_ready cycle.
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_div, w_div_nxt;
    logic [7:0]    r_wr_cnt, w_wr_cnt_nxt;
    logic [7:0]    r_rd_cnt, w_rd_cnt_nxt;
    logic [TW-1:0] r_turn_cnt, w_turn_cnt_nxt;
    logic          r_wait, w_wait_nxt;
    logic          r_sclk, w_sclk_nxt;
    logic          r_cs_n, w_cs_n_nxt;
    logic [7:0]    r_mosi, w_mosi_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_tx_ready, w_tx_ready_nxt;
    logic [7:0]    r_rx_data, w_rx_data_nxt;
    logic          r_rx_valid, w_rx_valid_nxt;

    logic          w_div_end;
    logic          w_enter;
    state_t        w_enter_st;
    state_t        w_after_wr;

    assign w_div_end  = (r_div == DIV_LAST);
    assign w_after_wr = (r_rd_cnt != 8'd0) ? (HAS_TURN ? ST_TURN : ST_READ) : ST_HOLD;

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_turn_cnt_nxt = r_turn_cnt;
        w_wait_nxt     = r_wait;
        w_sclk_nxt     = r_sclk;
        w_cs_n_nxt     = r_cs_n;
        w_mosi_nxt     = r_mosi;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_tx_ready_nxt = 1'b0;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_enter        = 1'b0;
        w_enter_st     = ST_HOLD;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_busy_nxt     = 1'b1;
                    w_cs_n_nxt     = 1'b0;
                    w_wr_cnt_nxt   = wr_len;
                    w_rd_cnt_nxt   = rd_len;
                    w_turn_cnt_nxt = TURN_LOAD;
                    w_div_nxt      = '0;
                    w_state_nxt    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_end) begin
                    w_enter    = 1'b1;
                    w_enter_st = (r_wr_cnt != 8'd0) ? ST_WRITE : w_after_wr;
                end
            end
            ST_WRITE, ST_TURN, ST_READ: begin
                if (r_state == ST_WRITE && r_wait) begin
                    // Stalled slot start: sclk and mosi hold until the source has a byte.
                    if (tx_valid) begin
                        w_wait_nxt     = 1'b0;
                        w_mosi_nxt     = tx_data;
                        w_tx_ready_nxt = 1'b1;
                        w_div_nxt      = '0;
                    end
                end else if (!w_div_end) begin
                    w_div_nxt = r_div + 1'b1;
                end else if (!r_sclk) begin
                    w_sclk_nxt = 1'b1;
                    w_div_nxt  = '0;
                end else begin
                    w_enter = 1'b1;
                    case (r_state)
                        ST_WRITE: begin
                            w_wr_cnt_nxt = r_wr_cnt - 8'd1;
                            w_enter_st   = (r_wr_cnt == 8'd1) ? w_after_wr : ST_WRITE;
                        end
                        ST_TURN: begin
                            w_turn_cnt_nxt = r_turn_cnt - 1'b1;
                            w_enter_st     = (r_turn_cnt == TW'(1)) ? ST_READ : ST_TURN;
                        end
                        default: begin
                            w_rd_cnt_nxt   = r_rd_cnt - 8'd1;
                            w_rx_data_nxt  = miso;
                            w_rx_valid_nxt = 1'b1;
                            w_enter_st     = (r_rd_cnt == 8'd1) ? ST_HOLD : ST_READ;
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_end) begin
                    w_cs_n_nxt  = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_div_nxt = r_div + 1'b1;
                if (w_div_end) begin
                    w_busy_nxt  = 1'b0;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every phase entry is the start of a low phase, the only point mosi may change.
        if (w_enter) begin
            w_state_nxt = w_enter_st;
            w_div_nxt   = '0;
            w_sclk_nxt  = 1'b0;
            if (w_enter_st == ST_WRITE) begin
                if (tx_valid) begin
                    w_wait_nxt     = 1'b0;
                    w_mosi_nxt     = tx_data;
                    w_tx_ready_nxt = 1'b1;
                end else begin
                    w_wait_nxt = 1'b1;
                end
            end else begin
                w_mosi_nxt = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_wr_cnt   <= 8'd0;
            r_rd_cnt   <= 8'd0;
            r_turn_cnt <= '0;
            r_wait     <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_ready <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
            r_wait     <= w_wait_nxt;
            r_sclk     <= w_sclk_nxt;
            r_cs_n     <= w_cs_n_nxt;
            r_mosi     <= w_mosi_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
        end
    end

    assign sclk     = r_sclk;
    assign cs_n     = r_cs_n;
    assign mosi     = r_mosi;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_wide_host.sv
// Directed bench for spi_wide_host: default instance (CLK_DIV=2, TURNAROUND=1)
// and a fast instance (CLK_DIV=1, TURNAROUND=0) with a simple SPI target model on each.
`timescale 1ns/1ps

module tb_spi_wide_host;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic       start;
    logic [7:0] wr_len, rd_len;
    logic       busy, done, tx_valid, tx_ready, rx_valid, sclk, cs_n;
    logic [7:0] tx_data, rx_data, mosi;
    logic [7:0] miso = 8'h00;

    // fast instance
    logic       f_start;
    logic [7:0] f_wr_len, f_rd_len;
    logic       f_busy, f_done, f_tx_valid, f_tx_ready, f_rx_valid, f_sclk, f_cs_n;
    logic [7:0] f_tx_data, f_rx_data, f_mosi;
    logic [7:0] f_miso = 8'h00;

    spi_wide_host #(.CLK_DIV(2), .TURNAROUND(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .wr_len(wr_len), .rd_len(rd_len),
        .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_wide_host #(.CLK_DIV(1), .TURNAROUND(0)) u_fast (
        .clk(clk), .rst(rst), .start(f_start), .wr_len(f_wr_len), .rd_len(f_rd_len),
        .busy(f_busy), .done(f_done), .tx_data(f_tx_data), .tx_valid(f_tx_valid),
        .tx_ready(f_tx_ready), .rx_data(f_rx_data), .rx_valid(f_rx_valid),
        .sclk(f_sclk), .cs_n(f_cs_n), .mosi(f_mosi), .miso(f_miso)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- default-instance source, target and monitor ----------------
    logic [7:0] tx_mem [64];
    logic [7:0] miso_mem [64];
    logic [7:0] mosi_log [64];
    logic [7:0] rx_log [64];
    logic       tx_en = 1'b0;
    int         tx_lim = 0;

    int cyc = 0, cs_low = 0, busy_hi = 0, done_cnt = 0, rxv_cnt = 0, txr_cnt = 0, rise_cnt = 0;
    int done_cyc = 0, busy_fall_cyc = 0, hi_run = 0, last_hi_run = 0;
    int lo_busy_run = 0, last_busy_lo_run = 0;
    logic done_csn = 1'b0, prev_busy = 1'b0, prev_csn = 1'b1;

    assign tx_valid = tx_en && (txr_cnt < tx_lim);
    assign tx_data  = tx_mem[txr_cnt[5:0]];

    always @(posedge sclk) begin
        mosi_log[rise_cnt[5:0]] = mosi;
        miso = miso_mem[rise_cnt[5:0]];
        rise_cnt++;
    end

    always @(negedge clk) begin
        cyc++;
        if (cs_n == 1'b0) cs_low++;
        if (busy == 1'b1) busy_hi++;
        if (tx_ready == 1'b1) txr_cnt++;
        if (rx_valid == 1'b1) begin
            rx_log[rxv_cnt[5:0]] = rx_data;
            rxv_cnt++;
        end
        if (done == 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_csn = cs_n;
        end
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        if (cs_n == 1'b1) hi_run++;
        else begin
            if (prev_csn) last_hi_run = hi_run;
            hi_run = 0;
        end
        if (busy == 1'b0) lo_busy_run++;
        else begin
            if (!prev_busy) last_busy_lo_run = lo_busy_run;
            lo_busy_run = 0;
        end
        prev_busy = busy;
        prev_csn  = cs_n;
    end

    // ---------------- fast-instance source, target and monitor ----------------
    logic [7:0] f_miso_mem [4];
    logic [7:0] f_mosi_log [4];
    int   f_rise_cyc [4];
    logic f_tx_en = 1'b0;
    int   f_txr = 0, f_cyc = 0, f_cs_low = 0, f_rise = 0, f_rise_n = 0;
    int   f_rxv = 0, f_rx_at = 0, f_done_cnt = 0;
    logic [7:0] f_rx_last = 8'h00;
    logic f_sclk_prev = 1'b0;

    assign f_tx_valid = f_tx_en && (f_txr < 1);
    assign f_tx_data  = 8'h5A;

    always @(posedge f_sclk) begin
        if (f_rise < 4) begin
            f_mosi_log[f_rise] = f_mosi;
            f_miso = f_miso_mem[f_rise];
        end
        f_rise++;
    end

    always @(negedge clk) begin
        f_cyc++;
        if (f_cs_n == 1'b0) f_cs_low++;
        if (f_tx_ready == 1'b1) f_txr++;
        if (f_rx_valid == 1'b1) begin
            f_rxv++;
            f_rx_last = f_rx_data;
            f_rx_at   = f_cs_low;
        end
        if (f_done == 1'b1) f_done_cnt++;
        if (f_sclk && !f_sclk_prev) begin
            if (f_rise_n < 4) f_rise_cyc[f_rise_n] = f_cyc;
            f_rise_n++;
        end
        f_sclk_prev = f_sclk;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", (done_cnt >= target), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic run_txn(input logic [7:0] w, input logic [7:0] r);
        int d0;
        d0 = done_cnt;
        start  = 1'b1;
        wr_len = w;
        rd_len = r;
        @(negedge clk);
        start = 1'b0;
        check("accept", {30'd0, cs_n, busy}, 32'd1);
        wait_done(d0 + 1);
        wait_idle();
    endtask

    int b_cs, b_rise, b_rx, b_done, b_txr, b_busy, stall_bad, k;

    task automatic snap();
        b_cs   = cs_low;
        b_rise = rise_cnt;
        b_rx   = rxv_cnt;
        b_done = done_cnt;
        b_txr  = txr_cnt;
        b_busy = busy_hi;
    endtask

    initial begin
        start = 1'b0; wr_len = 8'd0; rd_len = 8'd0;
        f_start = 1'b0; f_wr_len = 8'd0; f_rd_len = 8'd0;
        for (int i = 0; i < 64; i++) begin
            tx_mem[i]   = 8'h00;
            miso_mem[i] = 8'h00;
        end
        f_miso_mem[0] = 8'h11; f_miso_mem[1] = 8'hC3;
        f_miso_mem[2] = 8'h00; f_miso_mem[3] = 8'h00;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_fast_cs_n", f_cs_n, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic write 2 / read 1 with one turnaround slot
        snap();
        tx_mem[txr_cnt[5:0]] = 8'hA5;
        tx_mem[6'(txr_cnt + 1)] = 8'h3C;
        tx_lim = txr_cnt + 2;
        tx_en  = 1'b1;
        miso_mem[6'(rise_cnt + 3)] = 8'h7E;
        run_txn(8'd2, 8'd1);
        check("t1_cs_low", cs_low - b_cs, 20);
        check("t1_rises", rise_cnt - b_rise, 4);
        check("t1_mosi0", mosi_log[6'(b_rise)], 8'hA5);
        check("t1_mosi1", mosi_log[6'(b_rise + 1)], 8'h3C);
        check("t1_mosi2", mosi_log[6'(b_rise + 2)], 8'h00);
        check("t1_mosi3", mosi_log[6'(b_rise + 3)], 8'h00);
        check("t1_rx_count", rxv_cnt - b_rx, 1);
        check("t1_rx_data", rx_log[6'(b_rx)], 8'h7E);
        check("t1_tx_ready", txr_cnt - b_txr, 2);
        check("t1_done", done_cnt - b_done, 1);
        check("t1_done_cs_n", done_csn, 1);
        check("t1_busy_after_done", busy_fall_cyc - done_cyc, 2);

        // Write stall: tx_valid held low after SETUP
        tx_en = 1'b0;
        tx_mem[txr_cnt[5:0]] = 8'hC7;
        tx_lim = txr_cnt + 1;
        snap();
        start = 1'b1; wr_len = 8'd1; rd_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        stall_bad = 0;
        repeat (9) begin
            @(negedge clk);
            if (sclk !== 1'b0 || cs_n !== 1'b0 || tx_ready !== 1'b0) stall_bad++;
        end
        check("t2_stall_lines", stall_bad, 0);
        tx_en = 1'b1;
        @(negedge clk);
        check("t2_ready_on_valid", tx_ready, 1);
        wait_done(b_done + 1);
        wait_idle();
        check("t2_rises", rise_cnt - b_rise, 1);
        check("t2_mosi", mosi_log[6'(b_rise)], 8'hC7);
        check("t2_tx_ready", txr_cnt - b_txr, 1);
        check("t2_rx_count", rxv_cnt - b_rx, 0);
        check("t2_done", done_cnt - b_done, 1);

        // Empty transaction
        snap();
        run_txn(8'd0, 8'd0);
        check("t3_cs_low", cs_low - b_cs, 4);
        check("t3_rises", rise_cnt - b_rise, 0);
        check("t3_done", done_cnt - b_done, 1);
        check("t3_busy_cycles", busy_hi - b_busy, 6);

        // Back-to-back reads with start held high
        snap();
        miso_mem[6'(b_rise + 1)] = 8'h01; miso_mem[6'(b_rise + 2)] = 8'h02;
        miso_mem[6'(b_rise + 3)] = 8'h03; miso_mem[6'(b_rise + 5)] = 8'h01;
        miso_mem[6'(b_rise + 6)] = 8'h02; miso_mem[6'(b_rise + 7)] = 8'h03;
        start = 1'b1; wr_len = 8'd0; rd_len = 8'd3;
        wait_done(b_done + 2);
        start = 1'b0;
        wait_idle();
        check("t4_done", done_cnt - b_done, 2);
        check("t4_cs_low", cs_low - b_cs, 40);
        check("t4_rx_count", rxv_cnt - b_rx, 6);
        for (int i = 0; i < 6; i++)
            check("t4_rx_data", rx_log[6'(b_rx + i)], 32'((i % 3) + 1));
        check("t4_busy_low_gap", last_busy_lo_run, 1);
        check("t4_cs_high_min", (last_hi_run >= 2), 1);

        // Reset in the middle of the read phase
        tx_mem[txr_cnt[5:0]] = 8'h42;
        tx_lim = txr_cnt + 1;
        snap();
        start = 1'b1; wr_len = 8'd1; rd_len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (rxv_cnt == b_rx && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t5_read_reached", (rxv_cnt > b_rx), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_cs_n", cs_n, 1);
        check("t5_rst_sclk", sclk, 0);
        check("t5_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt - b_done, 0);

        tx_mem[txr_cnt[5:0]] = 8'h6D;
        tx_lim = txr_cnt + 1;
        snap();
        miso_mem[6'(b_rise + 2)] = 8'h99;
        run_txn(8'd1, 8'd1);
        check("t5_cs_low", cs_low - b_cs, 16);
        check("t5_rises", rise_cnt - b_rise, 3);
        check("t5_mosi", mosi_log[6'(b_rise)], 8'h6D);
        check("t5_rx_count", rxv_cnt - b_rx, 1);
        check("t5_rx_data", rx_log[6'(b_rx)], 8'h99);
        check("t5_done", done_cnt - b_done, 1);

        // Fast instance: CLK_DIV=1, no turnaround
        f_tx_en = 1'b1;
        f_start = 1'b1; f_wr_len = 8'd1; f_rd_len = 8'd1;
        @(negedge clk);
        f_start = 1'b0;
        k = 0;
        while (f_done_cnt == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("t6_done", f_done_cnt, 1);
        check("t6_cs_low", f_cs_low, 6);
        check("t6_rises", f_rise, 2);
        check("t6_sclk_period", f_rise_cyc[1] - f_rise_cyc[0], 2);
        check("t6_mosi0", f_mosi_log[0], 8'h5A);
        check("t6_mosi1", f_mosi_log[1], 8'h00);
        check("t6_rx_count", f_rxv, 1);
        check("t6_rx_data", f_rx_last, 8'hC3);
        check("t6_rx_at_last_slot", f_rx_at, 6);
        check("t6_tx_ready", f_txr, 1);
        check("t6_busy", f_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
